// File: rtl/device_event_serializer_if.sv
// Event bus between the activity-line serializer and the active-device monitor.
// The master side watches the device lines and issues change/on_off pulses.
interface device_event_serializer_if #(
  parameter int N_DEV = 8,
  parameter int ID_W  = 3
);
  logic             en;
  logic [N_DEV-1:0] dev_active;
  logic             change;
  logic             on_off;
  logic [ID_W-1:0]  dev_id;
  logic             busy;

  modport master (
    input  en,
    input  dev_active,
    output change,
    output on_off,
    output dev_id,
    output busy
  );

  modport slave (
    output en,
    output dev_active,
    input  change,
    input  on_off,
    input  dev_id,
    input  busy
  );
endinterface

// File: rtl/device_event_serializer.sv
// Turns per-device on/off transitions into a one-per-cycle stream of
// change/on_off pulses, holding one pending state (NONE/ON/OFF) per device.
module device_event_serializer #(
  parameter int N_DEV = 8,
  parameter int ID_W  = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  device_event_serializer_if.master bus
);

  logic [N_DEV-1:0] prev_r;
  logic [N_DEV-1:0] pend_on_r;
  logic [N_DEV-1:0] pend_off_r;
  logic             change_r;
  logic             on_off_r;
  logic [ID_W-1:0]  dev_id_r;
  logic             busy_r;

  logic [N_DEV-1:0] rise_s;
  logic [N_DEV-1:0] fall_s;
  logic [N_DEV-1:0] pend_any_s;
  logic [N_DEV-1:0] grant_oh_s;
  logic [N_DEV-1:0] on_post_s;
  logic [N_DEV-1:0] off_post_s;
  logic [N_DEV-1:0] pend_on_nxt_s;
  logic [N_DEV-1:0] pend_off_nxt_s;
  logic             grant_vld_s;
  logic             grant_dir_s;
  logic [ID_W-1:0]  grant_idx_s;

  assign rise_s     = bus.dev_active & ~prev_r;
  assign fall_s     = ~bus.dev_active & prev_r;
  assign pend_any_s = pend_on_r | pend_off_r;

  // Lowest pending index wins: isolate the least significant set bit.
  always_comb begin
    grant_oh_s  = {N_DEV{1'b0}};
    grant_vld_s = 1'b0;
    if (bus.en) begin
      grant_oh_s  = pend_any_s & (~pend_any_s + N_DEV'(1));
      grant_vld_s = |pend_any_s;
    end else begin
      grant_oh_s  = {N_DEV{1'b0}};
      grant_vld_s = 1'b0;
    end
  end

  // Encode the one-hot grant into a device index.
  always_comb begin
    grant_idx_s = {ID_W{1'b0}};
    for (int i = 0; i < N_DEV; i++) begin
      grant_idx_s = grant_idx_s | (grant_oh_s[i] ? ID_W'(i) : {ID_W{1'b0}});
    end
  end

  assign grant_dir_s = |(pend_on_r & grant_oh_s);

  // The granted device is cleared first, then its edge is applied; an edge
  // opposite to a still-pending event cancels it instead of queuing a new one.
  assign on_post_s      = pend_on_r  & ~grant_oh_s;
  assign off_post_s     = pend_off_r & ~grant_oh_s;
  assign pend_on_nxt_s  = (rise_s & ~off_post_s) | (~rise_s & ~fall_s & on_post_s);
  assign pend_off_nxt_s = (fall_s & ~on_post_s)  | (~rise_s & ~fall_s & off_post_s);

  // Edge-detect baseline, pending state and busy flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_r     <= {N_DEV{1'b0}};
      pend_on_r  <= {N_DEV{1'b0}};
      pend_off_r <= {N_DEV{1'b0}};
      busy_r     <= 1'b0;
    end else begin
      prev_r     <= bus.dev_active;
      pend_on_r  <= pend_on_nxt_s;
      pend_off_r <= pend_off_nxt_s;
      busy_r     <= |(pend_on_nxt_s | pend_off_nxt_s);
    end
  end

  // Registered event issue; direction and index hold while idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      change_r <= 1'b0;
      on_off_r <= 1'b0;
      dev_id_r <= {ID_W{1'b0}};
    end else begin
      change_r <= grant_vld_s;
      if (grant_vld_s) begin
        on_off_r <= grant_dir_s;
        dev_id_r <= grant_idx_s;
      end else begin
        on_off_r <= on_off_r;
        dev_id_r <= dev_id_r;
      end
    end
  end

  assign bus.change = change_r;
  assign bus.on_off = on_off_r;
  assign bus.dev_id = dev_id_r;
  assign bus.busy   = busy_r;

endmodule

// File: doc/device_event_serializer.md
Name: device_event_serializer

Overview:
- Upstream feeder for the active IoT devices monitor (the 8-bit up/down active-device counter).
- Watches N per-device activity lines and detects on/off transitions.
- Holds transitions as per-device pending events.
- Issues them one per cycle as the monitor's change/on_off pulse pair, so simultaneous transitions are never lost or merged into a single count step.

Parameters:
N_DEV, 8, number of monitored device lines (1..256)
ID_W, 3, width of dev_id; must satisfy N_DEV <= 2**ID_W

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
en  input  1  issue enable; 0 stalls event issue, edge capture continues
dev_active  input  N_DEV  per-device activity level, synchronous to clk, 1 = device on
change  output  1  one-cycle event strobe, drives monitor change
on_off  output  1  event direction when change=1: 1 = device turned on (count up), 0 = turned off (count down)
dev_id  output  ID_W  index of the device whose event is being issued
busy  output  1  1 while any event is pending

Behaviour:
- Reset (rst=0, asynchronous): prev=0, pend_on=0, pend_off=0, change=0, on_off=0, dev_id=0, busy=0. Reset mid-operation discards all pending events.
- Baseline after reset is prev=0, so devices already active at reset release each produce one ON event.
- Edge detect, per clock, combinational from registers:
  - rise = dev_active & ~prev
  - fall = ~dev_active & prev
  - prev <= dev_active
- Per-device pending state is NONE, ON or OFF (pend_on[i] and pend_off[i] never both 1).
- Grant, combinational:
  - If en=1 and (pend_on|pend_off) != 0, grant the lowest index g with a pending event. Fixed priority; no fairness requirement.
  - Registered issue: change <= 1, on_off <= pend_on[g], dev_id <= g.
  - Otherwise change <= 0; on_off and dev_id hold their previous values.
- Pending update order within one cycle:
  - First clear the granted device's state to NONE.
  - Then apply that device's edge to the post-grant state:
    - rise with state OFF -> NONE (cancel)
    - rise otherwise -> ON
    - fall with state ON -> NONE (cancel)
    - fall otherwise -> OFF
- Cancellation: an on-then-off (or off-then-on) pair that toggles before issue is removed. Net effect on the monitor count is zero and no pulses are emitted.
- Latency:
  - dev_active changes before clock edge k -> pending set at edge k.
  - If it is the lowest pending index and en=1, change=1 is registered at edge k+1.
  - Throughput: one event per cycle; back-to-back change pulses allowed.
- busy = |(pend_on|pend_off), registered view. busy=0 implies every issued event has been accounted for.
- Invariant, checked by the bench: (#ON issued − #OFF issued) == popcount(prev) whenever busy=0.
- No overflow case: pending storage is one state per device, so there can be at most N_DEV outstanding events.
- en=0: no issue, change=0. Edges keep updating pending state, including cancellations. Issue resumes on the first cycle with en=1.

Test Plan:
- Reset hold: rst=0 with dev_active=8'hFF for 3 cycles -> change=0, busy=0, dev_id=0. Release rst -> 8 ON pulses on consecutive cycles, dev_id 0..7, then busy=0.
- Single device: after idle, set dev_active[3]=1 -> exactly one change pulse 2 edges later, on_off=1, dev_id=3. Clear bit 3 -> one pulse with on_off=0, dev_id=3.
- Simultaneous: dev_active 8'h00 -> 8'hA5 in one cycle -> 4 consecutive ON pulses with dev_id 0,2,5,7, then 8'hA5 -> 8'h00 -> 4 OFF pulses in the same order.
- Cancellation: en=0, pulse dev_active[6] high for 1 cycle then low, raise en -> no change pulse, busy=0 throughout after the fall.
- Service/edge collision: bit 1 pending ON is granted in the same cycle bit 1 falls -> one ON pulse (dev_id=1), then one OFF pulse (dev_id=1).
- Random toggling of dev_active over 2000 cycles with random en, driving the monitor -> the monitor's counter_out equals popcount(prev) whenever busy=0; change is never high for more than one event per cycle.
